ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 11: RAM word-address width.
REQ-002 Parameter MAXBURST, default 16: maximum consecutive locked grants to port 1 while port 0 is waiting.
REQ-003 clk  input  1: single system clock; all state changes on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 m0_req  input  1: port 0 (CPU) access request.
REQ-006 m0_we  input  4: port 0 byte-lane write strobes; 0 means read.
REQ-007 m0_addr  input  AW: port 0 word address.
REQ-008 m0_wdata  input  32: port 0 write data.
REQ-009 m0_gnt  output  1: port 0 access is performed this cycle.
REQ-010 m0_rvalid  output  1: port 0 read data valid.
REQ-011 m1_req, m1_we, m1_addr, m1_wdata  input  1/4/AW/32: port 1 (UART burst loader) request, strobes, address and data.
REQ-012 m1_lock  input  1: port 1 asks to keep the grant for the next cycle (burst).
REQ-013 m1_gnt, m1_rvalid  output  1/1: port 1 grant and read-valid.
REQ-014 rdata  output  32: read data shared by both ports, qualified by mX_rvalid.
REQ-015 ram_re, ram_wrlanes, ram_addr, ram_wdata  output  1/4/AW/32: drive to the RAM with its synchronous read.
REQ-016 ram_rdata  input  32: RAM read data, valid one cycle after ram_re.

Function
REQ-017 Grant is combinational from the current state and requests. At most one of m0_gnt and m1_gnt is high in any cycle, and never with its req low.
REQ-018 Exactly one request high: that port is granted.
REQ-019 Both requests high with no active lock: the port NOT granted most recently wins. The tie-breaker state "last" updates on every granted cycle.
REQ-020 Lock state: set when m1 is granted with m1_lock=1. While set, m1 keeps priority on the next cycle if m1_req=1.
REQ-021 Burst counter: increments on each m1 grant in lock state while m0_req=1.
- When the count reaches MAXBURST, the next contested cycle grants m0 and clears the lock.
- The counter clears whenever m1 is not granted or m1_lock=0.
REQ-022 Lock with m1_req=0: lock clears and normal arbitration applies that cycle.
REQ-023 RAM outputs when port X is granted:
- ram_re=1, ram_wrlanes=mX_we, ram_addr=mX_addr, ram_wdata=mX_wdata.
- With no grant: ram_re=0, ram_wrlanes=0, address and data hold the m0 values.
REQ-024 A granted read (mX_we=0) asserts mX_rvalid exactly one cycle later with rdata=ram_rdata. Latency is 1 cycle and reads are fully pipelined: back-to-back grants give back-to-back rvalids.
REQ-025 A granted write produces no rvalid. The write commits in the grant cycle.
REQ-026 A requester holds req, we, addr and wdata stable until its gnt is high. A deasserted req cancels the request with no side effect.
REQ-027 An idle cycle (no requests) leaves "last" and the lock unchanged.

Reset
REQ-028 While reset=1, all of the following hold:
- m0_gnt=0, m1_gnt=0, ram_re=0, ram_wrlanes=0.
- m0_rvalid=0, m1_rvalid=0.
- last=port 1, so port 0 wins the first tie.
- Lock cleared, burst counter=0.
REQ-029 Reset asserted mid-burst or with a read outstanding discards the pending rvalid. No rvalid appears in the cycle after reset is released.

Structure
REQ-030 Port indices, the reset value of "last", and the MAXBURST default live in the shared SoC defines include. RAM width constants are taken from the same include.
REQ-031 The lock/burst-counter logic is one sub-module, burst_limiter (inputs: grant, lock, contend; output: force_yield). Arbitration and the RAM mux stay in ram_arbiter.

Verification
REQ-032 Only m0 reads addr 0x010 holding 0x12345678 -> m0_gnt same cycle, m0_rvalid next cycle with rdata=0x12345678, m1_rvalid=0.
REQ-033 Both ports request every cycle, no lock, after reset -> grants alternate m0,m1,m0,m1. The first grant goes to m0.
REQ-034 m1 writes 20 words with m1_lock=1 while m0 requests continuously, MAXBURST=16 -> 16 consecutive m1 grants, then 1 m0 grant, then m1 resumes.
REQ-035 m1 write with we=4'b0011, addr 0x7FF, wdata 0xAABBCCDD, then m0 read of 0x7FF -> m0 gets 0x????CCDD, with the upper bytes unchanged from the prior contents.
REQ-036 Reset asserted in the cycle after a granted m0 read -> m0_rvalid=0 during and after reset. First post-reset tie goes to m0.
REQ-037 m0 drops req before being granted while m1 holds the lock -> no RAM access for m0 and no m0_rvalid.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-port RAM arbiter: port identities, the tie-breaker
// reset value, default burst limit and RAM word geometry.
package ram_arbiter_pkg;

  localparam int DATA_W           = 32;
  localparam int WE_W             = DATA_W / 8;
  localparam int MAXBURST_DEFAULT = 16;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_e;

  // Port 1 counts as most recently granted out of reset, so port 0 wins the first tie.
  localparam port_e LAST_RESET = PORT_M1;

endpackage

// File: rtl/ram_arbiter_burst_limiter.sv
// Lock and burst-length tracking for port 1: keeps the lock across granted cycles
// and asks for a yield once MAXBURST locked grants have starved port 0.
module burst_limiter
  import ram_arbiter_pkg::*;
#(
  parameter int MAXBURST = MAXBURST_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_i,
  input  logic lock_i,
  input  logic contend_i,
  output logic locked_o,
  output logic force_yield_o
);

  localparam int CW = $clog2(MAXBURST + 1);

  logic          lock_q, lock_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
    end
  end

  // Without a port 1 grant, a pending port 0 request means port 0 took the cycle,
  // which ends the burst; a fully idle cycle keeps the lock.
  always_comb begin
    lock_d = lock_q;
    cnt_d  = '0;
    if (grant_i) begin
      lock_d = lock_i;
      if (lock_i) begin
        cnt_d = contend_i ? cnt_q + 1'b1 : cnt_q;
      end
    end else if (contend_i) begin
      lock_d = 1'b0;
    end
  end

  assign locked_o      = lock_q;
  assign force_yield_o = (cnt_q == CW'(MAXBURST));

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a synchronous-read RAM: port 0 (CPU) and port 1
// (burst loader) share one access per cycle with fair alternation and bounded bursts.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW       = 11,
  parameter int MAXBURST = MAXBURST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [WE_W-1:0]   m0_we,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic [WE_W-1:0]   m1_we,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_re,
  output logic [WE_W-1:0]   ram_wrlanes,
  output logic [AW-1:0]     ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  port_e last_q, last_d;
  logic  rv0_q, rv0_d;
  logic  rv1_q, rv1_d;
  logic  locked, force_yield;

  burst_limiter #(
    .MAXBURST (MAXBURST)
  ) u_burst_limiter (
    .clk           (clk),
    .reset         (reset),
    .grant_i       (m1_gnt),
    .lock_i        (m1_lock),
    .contend_i     (m0_req),
    .locked_o      (locked),
    .force_yield_o (force_yield)
  );

  // Grant decision, purely combinational from state and current requests.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        if (locked) begin
          m1_gnt = !force_yield;
        end else begin
          m1_gnt = (last_q == PORT_M0);
        end
        m0_gnt = !m1_gnt;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (m1_gnt) begin
      last_d = PORT_M1;
    end else if (m0_gnt) begin
      last_d = PORT_M0;
    end
    rv0_d = m0_gnt && (m0_we == '0);
    rv1_d = m1_gnt && (m1_we == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= LAST_RESET;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      rv0_q  <= rv0_d;
      rv1_q  <= rv1_d;
    end
  end

  // Idle cycles park address/data on port 0 so the RAM pins only toggle with the CPU.
  always_comb begin
    ram_re      = m0_gnt || m1_gnt;
    ram_wrlanes = '0;
    ram_addr    = m0_addr;
    ram_wdata   = m0_wdata;
    if (m1_gnt) begin
      ram_wrlanes = m1_we;
      ram_addr    = m1_addr;
      ram_wdata   = m1_wdata;
    end else if (m0_gnt) begin
      ram_wrlanes = m0_we;
    end
  end

  assign m0_rvalid = rv0_q && !reset;
  assign m1_rvalid = rv1_q && !reset;
  assign rdata     = ram_rdata;

  a_onehot_gnt : assert property (@(posedge clk) !(m0_gnt && m1_gnt));
  a_gnt_has_req : assert property (@(posedge clk) (!m0_gnt || m0_req) && (!m1_gnt || m1_req));

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised and directed bench for ram_arbiter: a behavioural arbiter/memory model
// feeds a scoreboard that a separate monitor checks against the DUT.
module tb_ram_arbiter;

  localparam int AW   = 11;
  localparam int MAXB = 16;

  logic          clk;
  logic          reset;
  logic          m0_req, m1_req, m1_lock;
  logic [3:0]    m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   rdata;
  logic          ram_re;
  logic [3:0]    ram_wrlanes;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  ram_arbiter #(.AW(AW), .MAXBURST(MAXB)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rvalid   (m0_rvalid),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_lock     (m1_lock),
    .m1_gnt      (m1_gnt),
    .m1_rvalid   (m1_rvalid),
    .rdata       (rdata),
    .ram_re      (ram_re),
    .ram_wrlanes (ram_wrlanes),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM with synchronous read, driven by the DUT's RAM port.
  logic [31:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_re) begin
      for (int b = 0; b < 4; b++)
        if (ram_wrlanes[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_wrlanes == 4'b0) ram_rdata <= ram_mem[ram_addr];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          g0;
    logic          g1;
    logic          re;
    logic [3:0]    wl;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
  } exp_t;
  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd0_q[$];
  rd_t  rd1_q[$];

  // Reference model state
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int m_last;
  bit m_lock;
  int m_cnt;

  // Pending transaction per requester
  bit            p0_v, p1_v, p1_lk;
  logic [3:0]    p0_we, p1_we;
  logic [AW-1:0] p0_a, p1_a;
  logic [31:0]   p0_d, p1_d;

  function automatic logic [31:0] ref_access(input logic [3:0] we, input logic [AW-1:0] a,
                                             input logic [31:0] d);
    if (we == 4'b0) return ref_mem[a];
    for (int b = 0; b < 4; b++)
      if (we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    return 32'h0;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0) return AW'(11'h7FF);
    if (k == 1) return AW'(11'h010);
    return AW'($urandom_range(0, 15));
  endfunction

  task automatic drive_cycle(input bit rst);
    exp_t        e;
    rd_t         r;
    int          g;
    logic [31:0] m;
    reset    = rst;
    m0_req   = p0_v;  m0_we = p0_we; m0_addr = p0_a; m0_wdata = p0_d;
    m1_req   = p1_v;  m1_we = p1_we; m1_addr = p1_a; m1_wdata = p1_d;
    m1_lock  = p1_lk;
    g = 0;
    if (!rst) begin
      if (p0_v && p1_v) begin
        if (m_lock) g = (m_cnt < MAXB) ? 2 : 1;
        else        g = (m_last == 1) ? 1 : 2;
      end else if (p0_v) g = 1;
      else if (p1_v)     g = 2;
    end
    e.g0   = (g == 1);
    e.g1   = (g == 2);
    e.re   = (g != 0);
    e.wl   = (g == 1) ? p0_we : (g == 2) ? p1_we : 4'b0;
    e.addr = (g == 2) ? p1_a : p0_a;
    e.wd   = (g == 2) ? p1_d : p0_d;
    exp_q.push_back(e);
    r.cyc = cyc;
    if (rst) begin
      m_last = 1; m_lock = 0; m_cnt = 0;
      rd0_q.delete();
      rd1_q.delete();
    end else if (g == 1) begin
      m = ref_access(p0_we, p0_a, p0_d);
      if (p0_we == 4'b0) begin r.data = m; rd0_q.push_back(r); end
      m_last = 0; m_lock = 0; m_cnt = 0;
      p0_v = 0;
    end else if (g == 2) begin
      m = ref_access(p1_we, p1_a, p1_d);
      if (p1_we == 4'b0) begin r.data = m; rd1_q.push_back(r); end
      m_last = 1;
      if (p1_lk) begin
        m_lock = 1;
        if (p0_v) m_cnt++;
      end else begin
        m_lock = 0; m_cnt = 0;
      end
      p1_v = 0;
    end else begin
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d);
    p0_v = 1; p0_we = we; p0_a = a; p0_d = d;
  endtask

  task automatic set_p1(input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d,
                        input bit lk);
    p1_v = 1; p1_we = we; p1_a = a; p1_d = d; p1_lk = lk;
  endtask

  // Monitor: compares DUT outputs mid-cycle against the scoreboard queues.
  always @(negedge clk) begin
    exp_t e;
    rd_t  r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
        fails++;
        $display("FAIL grant cyc=%0d got m0=%b m1=%b expected m0=%b m1=%b",
                 cyc, m0_gnt, m1_gnt, e.g0, e.g1);
      end
      tests++;
      if ({ram_re, ram_wrlanes, ram_addr, ram_wdata} !== {e.re, e.wl, e.addr, e.wd}) begin
        fails++;
        $display("FAIL ram_bus cyc=%0d got re=%b wl=%h a=%h d=%h expected re=%b wl=%h a=%h d=%h",
                 cyc, ram_re, ram_wrlanes, ram_addr, ram_wdata, e.re, e.wl, e.addr, e.wd);
      end
      if (reset) begin
        tests++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
          fails++;
          $display("FAIL rvalid_in_reset cyc=%0d got %b%b expected 00", cyc, m0_rvalid, m1_rvalid);
        end
      end
    end
    if (m0_rvalid) begin
      tests++;
      if (rd0_q.size() == 0) begin
        fails++;
        $display("FAIL m0_rvalid cyc=%0d got unexpected rvalid expected none", cyc);
      end else begin
        r = rd0_q.pop_front();
        if (r.cyc + 1 != cyc || rdata !== r.data) begin
          fails++;
          $display("FAIL m0_rdata cyc=%0d got %h expected %h (granted cyc %0d)", cyc, rdata, r.data, r.cyc);
        end
      end
    end else if (rd0_q.size() > 0 && rd0_q[0].cyc + 1 <= cyc) begin
      tests++;
      fails++;
      $display("FAIL m0_rvalid cyc=%0d got none expected data %h", cyc, rd0_q[0].data);
      void'(rd0_q.pop_front());
    end
    if (m1_rvalid) begin
      tests++;
      if (rd1_q.size() == 0) begin
        fails++;
        $display("FAIL m1_rvalid cyc=%0d got unexpected rvalid expected none", cyc);
      end else begin
        r = rd1_q.pop_front();
        if (r.cyc + 1 != cyc || rdata !== r.data) begin
          fails++;
          $display("FAIL m1_rdata cyc=%0d got %h expected %h (granted cyc %0d)", cyc, rdata, r.data, r.cyc);
        end
      end
    end else if (rd1_q.size() > 0 && rd1_q[0].cyc + 1 <= cyc) begin
      tests++;
      fails++;
      $display("FAIL m1_rvalid cyc=%0d got none expected data %h", cyc, rd1_q[0].data);
      void'(rd1_q.pop_front());
    end
  end

  initial begin
    int nw;
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = 32'(i) * 32'h9E37_79B1 + 32'h0BAD_F00D;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[16] = 32'h1234_5678;     ref_mem[16] = 32'h1234_5678;
    ram_mem[2047] = 32'h1122_3344;   ref_mem[2047] = 32'h1122_3344;
    ram_rdata = 32'h0;
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    p0_v = 0; p0_we = 0; p0_a = 0; p0_d = 0;
    p1_v = 0; p1_we = 0; p1_a = 0; p1_d = 0; p1_lk = 0;
    m_last = 1; m_lock = 0; m_cnt = 0;
    @(posedge clk);
    #1;

    // Reset with both ports requesting: no grants.
    set_p0(4'b0, AW'(1), 32'h0);
    set_p1(4'b0, AW'(2), 32'h0, 1'b0);
    repeat (2) drive_cycle(1);

    // Both request every cycle without lock: alternation starting at m0.
    for (int i = 0; i < 8; i++) begin
      if (!p0_v) set_p0(4'b0, AW'(i + 3), 32'h0);
      if (!p1_v) set_p1(4'b0, AW'(i + 20), 32'h0, 1'b0);
      drive_cycle(0);
    end
    repeat (3) drive_cycle(0);

    // Lone m0 read of 0x010.
    set_p0(4'b0, AW'(11'h010), 32'h0);
    drive_cycle(0);
    drive_cycle(0);

    // Partial-lane write by m1 then m0 readback.
    set_p1(4'b0011, AW'(11'h7FF), 32'hAABB_CCDD, 1'b0);
    drive_cycle(0);
    set_p0(4'b0, AW'(11'h7FF), 32'h0);
    drive_cycle(0);
    repeat (2) drive_cycle(0);

    // 20-word locked m1 burst against continuous m0 traffic.
    nw = 0;
    for (int i = 0; i < 60 && (nw < 20 || p1_v); i++) begin
      if (!p1_v && nw < 20) begin
        set_p1(4'hF, AW'(11'h100 + nw), $urandom, 1'b1);
        nw++;
      end
      if (!p0_v) set_p0(4'b0, rand_addr(), 32'h0);
      drive_cycle(0);
    end
    p1_lk = 0;
    repeat (3) drive_cycle(0);

    // m0 gives up while m1 holds the lock.
    set_p1(4'hF, AW'(11'h200), $urandom, 1'b1);
    drive_cycle(0);
    set_p0(4'b0, AW'(11'h200), 32'h0);
    for (int i = 0; i < 2; i++) begin
      set_p1(4'hF, AW'(11'h201 + i), $urandom, 1'b1);
      drive_cycle(0);
    end
    p0_v = 0;
    for (int i = 0; i < 2; i++) begin
      set_p1(4'hF, AW'(11'h203 + i), $urandom, 1'b1);
      drive_cycle(0);
    end
    repeat (2) drive_cycle(0);

    // Reset right after a granted m0 read; first post-reset tie goes to m0.
    set_p0(4'b0, AW'(11'h010), 32'h0);
    drive_cycle(0);
    set_p0(4'b0, AW'(5), 32'h0);
    set_p1(4'b0, AW'(6), 32'h0, 1'b0);
    repeat (2) drive_cycle(1);
    repeat (3) drive_cycle(0);

    // Randomised traffic with occasional resets and lock-heavy phases.
    for (int i = 0; i < 800; i++) begin
      bit lock_phase;
      lock_phase = (i % 200) < 100;
      if (!p0_v && $urandom_range(0, 99) < 60)
        set_p0(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0,
               rand_addr(), $urandom);
      else if (p0_v && $urandom_range(0, 99) < 5)
        p0_v = 0;
      if (!p1_v && $urandom_range(0, 99) < (lock_phase ? 90 : 50))
        set_p1(($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom_range(1, 15)),
               rand_addr(), $urandom, 1'b0);
      else if (p1_v && $urandom_range(0, 99) < 3)
        p1_v = 0;
      p1_lk = ($urandom_range(0, 99) < (lock_phase ? 95 : 30));
      drive_cycle($urandom_range(0, 199) < 2);
    end

    p0_v = 0;
    p1_v = 0;
    repeat (4) drive_cycle(0);

    tests++;
    if (rd0_q.size() + rd1_q.size() + exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d outstanding entries expected 0",
               rd0_q.size() + rd1_q.size() + exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
